// File: rtl/sys_defs.sv
// Shared definitions for the processor-to-memory bus.
//   bus_command_t : encodings carried on every *_command port
//   arb_state_t   : arbiter sequencing states (run, drain for halt, halted)
//   count_ones    : population count used for the outstanding-load count
package sys_defs;

    localparam int STARVE_LIMIT = 4;
    localparam int NUM_TAGS     = 16;
    localparam int TAG_W        = $clog2(NUM_TAGS);
    localparam int COUNT_W      = TAG_W + 1;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_t;

    function automatic logic [COUNT_W-1:0] count_ones(input logic [NUM_TAGS-1:0] v);
        logic [COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            n = n + COUNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_owner_table.sv
// mem_tag_owner_table: remembers which cache issued each in-flight load tag.
//   i_alloc_en/i_alloc_tag/i_alloc_owner : record an accepted load (owner 1 = dcache)
//   i_ret_tag                            : tag of returning data (0 = no return)
//   o_ret_hit/o_ret_owner                : return belongs to a live entry, and whose
//   o_count                              : number of live entries
//   o_tag_err                            : sticky, a return arrived on a dead tag
module mem_tag_owner_table
    import sys_defs::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               i_alloc_en,
    input  logic [TAG_W-1:0]   i_alloc_tag,
    input  logic               i_alloc_owner,
    input  logic [TAG_W-1:0]   i_ret_tag,
    output logic               o_ret_hit,
    output logic               o_ret_owner,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_tag_err
);

    logic [NUM_TAGS-1:0] r_valid;
    logic [NUM_TAGS-1:0] r_owner;
    logic                r_tag_err;
    logic                w_ret_active;

    assign w_ret_active = (i_ret_tag != '0);
    assign o_ret_hit    = w_ret_active && r_valid[i_ret_tag];
    assign o_ret_owner  = r_owner[i_ret_tag];
    assign o_count      = count_ones(r_valid);
    assign o_tag_err    = r_tag_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid   <= '0;
            r_owner   <= '0;
            r_tag_err <= 1'b0;
        end else begin
            if (o_ret_hit) begin
                r_valid[i_ret_tag] <= 1'b0;
            end
            if (w_ret_active && !r_valid[i_ret_tag]) begin
                r_tag_err <= 1'b1;
            end
            // Placed after the clear so a same-cycle reuse of the tag survives.
            if (i_alloc_en && (i_alloc_tag != '0)) begin
                r_valid[i_alloc_tag] <= 1'b1;
                r_owner[i_alloc_tag] <= i_alloc_owner;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory bus between icache (loads) and dcache
// (loads/stores/writebacks), routes returning load tags to their issuer, and
// drains the bus on a halt.
//   icache_* / dcache_* : requester side (command, address, data, accept tag, return tag)
//   mem_*               : memory side; command forwarded combinationally, same-cycle accept tag
//   halt_req/halted     : halt drain handshake
//   outstanding/tag_err : in-flight load count, sticky unowned-return flag
//
// state     | meaning
// ST_RUN    | normal arbitration, dcache priority with icache starvation override
// ST_DRAIN  | icache blocked; dcache traffic and load returns finish
// ST_HALTED | bus idle until reset
module mem_bus_arbiter
    import sys_defs::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   icache_command,
    input  logic [63:0]  icache_addr,
    output logic [3:0]   icache_response,
    output logic [3:0]   icache_tag,
    input  logic [1:0]   dcache_command,
    input  logic [63:0]  dcache_addr,
    input  logic [63:0]  dcache_wdata,
    output logic [3:0]   dcache_response,
    output logic [3:0]   dcache_tag,
    output logic [63:0]  mem_rdata_out,
    output logic [1:0]   mem_command,
    output logic [63:0]  mem_addr,
    output logic [63:0]  mem_wdata,
    input  logic [3:0]   mem_response,
    input  logic [63:0]  mem_rdata,
    input  logic [3:0]   mem_tag,
    input  logic         halt_req,
    output logic         halted,
    output logic [4:0]   outstanding,
    output logic         tag_err
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t          r_state;
    logic                r_halted;
    logic [STARVE_W-1:0] r_starve_cnt;

    logic w_icache_req;
    logic w_dcache_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_accepted;
    logic w_alloc_en;
    logic w_ret_hit;
    logic w_ret_owner;
    logic w_tag_err;
    logic [COUNT_W-1:0] w_count;

    // A STORE from the icache is meaningless and is treated as no request.
    assign w_icache_req = (icache_command == BUS_LOAD);
    assign w_dcache_req = (dcache_command != BUS_NONE);
    assign w_accepted   = (mem_response != 4'd0);

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            ST_RUN: begin
                if ((r_starve_cnt == STARVE_W'(STARVE_LIMIT)) && w_icache_req) begin
                    w_grant_i = 1'b1;
                end else if (w_dcache_req) begin
                    w_grant_d = 1'b1;
                end else if (w_icache_req) begin
                    w_grant_i = 1'b1;
                end
            end
            ST_DRAIN: w_grant_d = w_dcache_req;
            default: ;
        endcase
    end

    always_comb begin
        mem_command = BUS_NONE;
        mem_addr    = 64'd0;
        mem_wdata   = 64'd0;
        if (w_grant_i) begin
            mem_command = BUS_LOAD;
            mem_addr    = icache_addr;
        end else if (w_grant_d) begin
            mem_command = dcache_command;
            mem_addr    = dcache_addr;
            mem_wdata   = dcache_wdata;
        end
    end

    assign icache_response = w_grant_i ? mem_response : 4'd0;
    assign dcache_response = w_grant_d ? mem_response : 4'd0;

    // Only loads expect data back, so only loads claim a tag.
    assign w_alloc_en = w_accepted &&
                        (w_grant_i || (w_grant_d && (dcache_command == BUS_LOAD)));

    mem_tag_owner_table u_owner_table (
        .clock         (clock),
        .reset         (reset),
        .i_alloc_en    (w_alloc_en),
        .i_alloc_tag   (mem_response),
        .i_alloc_owner (w_grant_d),
        .i_ret_tag     (mem_tag),
        .o_ret_hit     (w_ret_hit),
        .o_ret_owner   (w_ret_owner),
        .o_count       (w_count),
        .o_tag_err     (w_tag_err)
    );

    assign icache_tag    = (w_ret_hit && !w_ret_owner) ? mem_tag : 4'd0;
    assign dcache_tag    = (w_ret_hit &&  w_ret_owner) ? mem_tag : 4'd0;
    assign mem_rdata_out = mem_rdata;
    assign outstanding   = w_count;
    assign tag_err       = w_tag_err;
    assign halted        = r_halted;

    // A rejected grant keeps the count so the retry still wins next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!w_icache_req) begin
            r_starve_cnt <= '0;
        end else if (w_grant_i) begin
            if (w_accepted) begin
                r_starve_cnt <= '0;
            end
        end else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((w_count == '0) && (dcache_command == BUS_NONE)) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import sys_defs::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  icache_command;
    logic [63:0] icache_addr;
    logic [3:0]  icache_response;
    logic [3:0]  icache_tag;
    logic [1:0]  dcache_command;
    logic [63:0] dcache_addr;
    logic [63:0] dcache_wdata;
    logic [3:0]  dcache_response;
    logic [3:0]  dcache_tag;
    logic [63:0] mem_rdata_out;
    logic [1:0]  mem_command;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_response;
    logic [63:0] mem_rdata;
    logic [3:0]  mem_tag;
    logic        halt_req;
    logic        halted;
    logic [4:0]  outstanding;
    logic        tag_err;

    always #5 clock = ~clock;

    mem_bus_arbiter dut (
        .clock(clock), .reset(reset),
        .icache_command(icache_command), .icache_addr(icache_addr),
        .icache_response(icache_response), .icache_tag(icache_tag),
        .dcache_command(dcache_command), .dcache_addr(dcache_addr),
        .dcache_wdata(dcache_wdata), .dcache_response(dcache_response),
        .dcache_tag(dcache_tag), .mem_rdata_out(mem_rdata_out),
        .mem_command(mem_command), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_response(mem_response), .mem_rdata(mem_rdata), .mem_tag(mem_tag),
        .halt_req(halt_req), .halted(halted), .outstanding(outstanding),
        .tag_err(tag_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = running, 1 = draining, 2 = halted.
    int        m_mode,  nx_mode;
    bit [15:0] m_live,  nx_live;
    bit [15:0] m_isd,   nx_isd;
    int        m_wait,  nx_wait;
    bit        m_err,   nx_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_live = '0; m_isd = '0; m_wait = 0; m_err = 1'b0;
    endtask

    task automatic set_idle();
        reset = 1'b0; halt_req = 1'b0;
        icache_command = 2'd0; dcache_command = 2'd0;
        icache_addr = {$urandom, $urandom};
        dcache_addr = {$urandom, $urandom};
        dcache_wdata = {$urandom, $urandom};
        mem_rdata = {$urandom, $urandom};
        mem_response = 4'd0; mem_tag = 4'd0;
    endtask

    // Checks all outputs against the model and computes the model's next state.
    task automatic settle();
        int who;          // 0 nobody, 1 icache, 2 dcache
        bit iwant, dwant;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr, e_wdata;
        logic [3:0]  e_ir, e_dr, e_it, e_dt;
        #1;
        iwant = (icache_command == 2'd1);
        dwant = (dcache_command != 2'd0);
        who = 0;
        if (m_mode == 0) begin
            if (m_wait == STARVE_LIMIT && iwant) who = 1;
            else if (dwant)                      who = 2;
            else if (iwant)                      who = 1;
        end else if (m_mode == 1 && dwant) begin
            who = 2;
        end
        e_cmd   = (who == 1) ? 2'd1 : (who == 2) ? dcache_command : 2'd0;
        e_addr  = (who == 1) ? icache_addr : (who == 2) ? dcache_addr : 64'd0;
        e_wdata = (who == 2) ? dcache_wdata : 64'd0;
        e_ir    = (who == 1) ? mem_response : 4'd0;
        e_dr    = (who == 2) ? mem_response : 4'd0;
        e_it = 4'd0; e_dt = 4'd0;
        if (mem_tag != 0 && m_live[mem_tag]) begin
            if (m_isd[mem_tag]) e_dt = mem_tag;
            else                e_it = mem_tag;
        end
        chk("mem_command", mem_command, e_cmd);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("icache_response", icache_response, e_ir);
        chk("dcache_response", dcache_response, e_dr);
        chk("icache_tag", icache_tag, e_it);
        chk("dcache_tag", dcache_tag, e_dt);
        chk("mem_rdata_out", mem_rdata_out, mem_rdata);
        chk("halted", halted, (m_mode == 2) ? 64'd1 : 64'd0);
        chk("outstanding", outstanding, 64'($countones(m_live)));
        chk("tag_err", tag_err, 64'(m_err));

        nx_mode = m_mode; nx_live = m_live; nx_isd = m_isd; nx_wait = m_wait; nx_err = m_err;
        if (mem_tag != 0) begin
            if (m_live[mem_tag]) nx_live[mem_tag] = 1'b0;
            else                 nx_err = 1'b1;
        end
        if (mem_response != 0 && (who == 1 || (who == 2 && dcache_command == 2'd1))) begin
            nx_live[mem_response] = 1'b1;
            nx_isd[mem_response]  = (who == 2);
        end
        if (!iwant)                     nx_wait = 0;
        else if (who == 1)              nx_wait = (mem_response != 0) ? 0 : m_wait;
        else if (m_wait < STARVE_LIMIT) nx_wait = m_wait + 1;
        if (m_mode == 0 && halt_req) nx_mode = 1;
        if (m_mode == 1 && $countones(m_live) == 0 && dcache_command == 2'd0) nx_mode = 2;
        if (reset) begin
            nx_mode = 0; nx_live = '0; nx_isd = '0; nx_wait = 0; nx_err = 1'b0;
        end
    endtask

    task automatic advance();
        @(posedge clock);
        m_mode = nx_mode; m_live = nx_live; m_isd = nx_isd; m_wait = nx_wait; m_err = nx_err;
        @(negedge clock);
    endtask

    function automatic logic [3:0] pick_tag(input bit want_live);
        int start;
        start = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
            int t;
            t = ((start - 1 + k) % 15) + 1;
            if (m_live[t] == want_live) return 4'(t);
        end
        return 4'd0;
    endfunction

    task automatic rand_inputs();
        int r;
        set_idle();
        reset = ($urandom_range(0, 399) == 0) || (m_mode == 2 && $urandom_range(0, 19) == 0);
        r = $urandom_range(0, 9);
        icache_command = (r < 5) ? 2'd1 : (r == 5) ? 2'd2 : 2'd0;
        r = $urandom_range(0, 9);
        dcache_command = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : 2'd2;
        halt_req = (m_mode == 0) ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 9);
        if (r < 3)       mem_response = 4'd0;
        else if (r == 3) mem_response = pick_tag(1'b1);
        else             mem_response = pick_tag(1'b0);
        r = $urandom_range(0, 19);
        if (r < 9)        mem_tag = pick_tag(1'b1);
        else if (r == 9)  mem_tag = 4'($urandom_range(1, 15));
        else              mem_tag = 4'd0;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        model_reset();

        // Reset state
        set_idle();
        settle();
        chk("rst halted", halted, 0);
        chk("rst outstanding", outstanding, 0);
        chk("rst mem_command", mem_command, 0);
        chk("rst icache_response", icache_response, 0);
        chk("rst dcache_tag", dcache_tag, 0);
        advance();

        // Dcache load tagged 3, returned two cycles later
        set_idle(); dcache_command = 2'd1; mem_response = 4'd3;
        settle();
        chk("t1 dcache_response", dcache_response, 3);
        chk("t1 outstanding0", outstanding, 0);
        advance();
        set_idle(); settle();
        chk("t1 outstanding1", outstanding, 1);
        advance();
        set_idle(); mem_tag = 4'd3; settle();
        chk("t1 dcache_tag", dcache_tag, 3);
        chk("t1 icache_tag", icache_tag, 0);
        advance();
        set_idle(); settle();
        chk("t1 outstanding2", outstanding, 0);
        advance();

        // Both load: dcache wins four times, then the starved icache wins,
        // keeps winning after a rejection, and then dcache regains priority.
        for (int c = 0; c < 7; c++) begin
            set_idle(); icache_command = 2'd1; dcache_command = 2'd1;
            mem_response = (c < 4) ? 4'(c + 1) : (c == 4) ? 4'd0 : 4'(c);
            settle();
            if (c < 4 || c == 6) begin
                chk("t2 dcache_response", dcache_response, (c < 4) ? c + 1 : 6);
                chk("t2 icache_response lose", icache_response, 0);
            end else begin
                chk("t2 icache_response", icache_response, (c == 4) ? 0 : 5);
                chk("t2 dcache_response lose", dcache_response, 0);
                chk("t2 mem_command", mem_command, 1);
            end
            advance();
        end
        set_idle(); settle();
        chk("t2 outstanding", outstanding, 6);
        advance();
        for (int t = 1; t <= 6; t++) begin
            set_idle(); mem_tag = 4'(t); settle();
            chk("t2 return icache_tag", icache_tag, (t == 5) ? 5 : 0);
            chk("t2 return dcache_tag", dcache_tag, (t == 5) ? 0 : t);
            advance();
        end

        // Return and reuse of tag 5 in one cycle
        set_idle(); icache_command = 2'd1; mem_response = 4'd5; settle();
        chk("t5 icache_response", icache_response, 5);
        advance();
        set_idle(); dcache_command = 2'd1; mem_response = 4'd5; mem_tag = 4'd5; settle();
        chk("t5 icache_tag", icache_tag, 5);
        chk("t5 dcache_tag", dcache_tag, 0);
        chk("t5 dcache_response", dcache_response, 5);
        advance();
        set_idle(); mem_tag = 4'd5; settle();
        chk("t5 reuse dcache_tag", dcache_tag, 5);
        chk("t5 reuse icache_tag", icache_tag, 0);
        advance();

        // Return on an unowned tag
        set_idle(); mem_tag = 4'd7; settle();
        chk("t4 icache_tag", icache_tag, 0);
        chk("t4 dcache_tag", dcache_tag, 0);
        advance();
        for (int c = 0; c < 3; c++) begin
            set_idle(); settle();
            chk("t4 tag_err sticky", tag_err, 1);
            advance();
        end

        // Halt drain with two loads in flight
        set_idle(); dcache_command = 2'd1; mem_response = 4'd8; settle(); advance();
        set_idle(); icache_command = 2'd1; mem_response = 4'd9; settle(); advance();
        set_idle(); halt_req = 1'b1; settle(); advance();
        set_idle(); icache_command = 2'd1; mem_response = 4'd10; settle();
        chk("t6 drain icache_response", icache_response, 0);
        chk("t6 drain mem_command", mem_command, 0);
        advance();
        set_idle(); icache_command = 2'd1; dcache_command = 2'd2; mem_response = 4'd11; settle();
        chk("t6 drain store response", dcache_response, 11);
        chk("t6 drain store command", mem_command, 2);
        chk("t6 drain outstanding", outstanding, 2);
        advance();
        set_idle(); icache_command = 2'd1; mem_tag = 4'd8; settle();
        chk("t6 return 8", dcache_tag, 8);
        advance();
        set_idle(); icache_command = 2'd1; mem_tag = 4'd9; settle();
        chk("t6 return 9", icache_tag, 9);
        chk("t6 not halted yet", halted, 0);
        advance();
        set_idle(); settle();
        chk("t6 drained outstanding", outstanding, 0);
        advance();
        set_idle(); settle();
        chk("t6 halted", halted, 1);
        advance();
        set_idle(); dcache_command = 2'd2; mem_response = 4'd12; halt_req = 1'b1; settle();
        chk("t6 halted no grant", dcache_response, 0);
        chk("t6 halted mem_command", mem_command, 0);
        advance();
        set_idle(); reset = 1'b1; settle(); advance();
        set_idle(); settle();
        chk("post reset halted", halted, 0);
        chk("post reset tag_err", tag_err, 0);
        advance();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rand_inputs();
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
